// File: rtl/mips_bus_lsu.sv
// Load/store unit bridging the multicycle MIPS datapath to an Avalon-MM master port.
// Define MIPS_BUS_LSU_ALIGN_CHECK_EN to fault misaligned accesses instead of aligning them down.
module mips_bus_lsu #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [1:0]             req_size,
   input  logic                   req_signed,
   input  logic [ADDR_W-1:0]      req_addr,
   input  logic [DATA_W-1:0]      req_wdata,
   output logic                   resp_valid,
   output logic [DATA_W-1:0]      resp_rdata,
   output logic                   resp_fault,
   output logic [ADDR_W-1:0]      address,
   output logic                   read,
   output logic                   write,
   input  logic                   waitrequest,
   output logic [DATA_W-1:0]      writedata,
   output logic [DATA_W/8-1:0]    byteenable,
   input  logic [DATA_W-1:0]      readdata
);
   localparam int NB    = DATA_W / 8;
   localparam int OFS_W = $clog2(NB);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
   state_t state, state_next;

   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        size_q;
   logic              signed_q;
   logic              write_q;
   logic              fault_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;

   logic [ADDR_W-1:0] size_lsbs;
   logic [ADDR_W-1:0] addr_in;
   logic              illegal;

   // Low address bits that must be zero for an access of the requested size.
   always_comb begin
      size_lsbs = '0;
      case (req_size)
         2'd1:    size_lsbs = ADDR_W'(1);
         2'd2:    size_lsbs = ADDR_W'(3);
         2'd3:    size_lsbs = ADDR_W'(7);
         default: size_lsbs = '0;
      endcase
      illegal = (req_size == 2'd3) && (DATA_W == 32);
`ifdef MIPS_BUS_LSU_ALIGN_CHECK_EN
      illegal = illegal || ((req_addr & size_lsbs) != '0);
      addr_in = req_addr;
`else
      addr_in = req_addr & ~size_lsbs;
`endif
   end

   logic [OFS_W-1:0]  ofs;
   logic [NB-1:0]     lane_mask;
   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] load_val;
   logic              msb;

   assign ofs = addr_q[OFS_W-1:0];

   always_comb begin
      lane_mask = '0;
      case (size_q)
         2'd0:    lane_mask[0]   = 1'b1;
         2'd1:    lane_mask[1:0] = 2'b11;
         2'd2:    lane_mask[3:0] = 4'hF;
         default: lane_mask      = '1;
      endcase
   end

   // Right-justify the addressed field, then fill above it with zero or its sign bit.
   always_comb begin
      shifted = readdata >> {ofs, 3'b000};
      case (size_q)
         2'd0:    msb = shifted[7];
         2'd1:    msb = shifted[15];
         2'd2:    msb = shifted[31];
         default: msb = shifted[DATA_W-1];
      endcase
      load_val = '0;
      for (int i = 0; i < DATA_W; i++) begin
         load_val[i] = (i < (8 << size_q)) ? shifted[i] : (signed_q & msb);
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (req_valid) state_next = illegal ? RESP : BUS;
         BUS:     if (!waitrequest) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         addr_q   <= '0;
         size_q   <= '0;
         signed_q <= 1'b0;
         write_q  <= 1'b0;
         fault_q  <= 1'b0;
         wdata_q  <= '0;
         rdata_q  <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && req_valid) begin
            addr_q   <= addr_in;
            size_q   <= req_size;
            signed_q <= req_signed;
            write_q  <= req_write;
            fault_q  <= illegal;
            wdata_q  <= req_wdata;
            rdata_q  <= '0;
         end
         if (state == BUS && !waitrequest) begin
            rdata_q <= write_q ? '0 : load_val;
         end
      end
   end

   // Bus outputs derive only from captured request registers, so they stay put across waitrequest.
   assign read       = (state == BUS) && !write_q;
   assign write      = (state == BUS) && write_q;
   assign address    = (state == BUS) ? {addr_q[ADDR_W-1:OFS_W], {OFS_W{1'b0}}} : '0;
   assign byteenable = (state == BUS) ? (lane_mask << ofs) : '0;
   assign writedata  = (state == BUS) ? (wdata_q << {ofs, 3'b000}) : '0;

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign resp_fault = (state == RESP) && fault_q;
   assign resp_rdata = rdata_q;
endmodule

// File: doc/mips_bus_lsu.md
# mips_bus_lsu

Parametrised load/store unit between the multicycle MIPS core datapath and the Avalon memory-mapped bus master port. It accepts one byte/half/word (and doubleword when 64-bit) access per request, aligns the bus address, generates byteenable and write-lane steering, and holds the bus request stable across waitrequest. Read data is extracted, sign- or zero-extended, and returned through a one-cycle response strobe.

## Interface
- DATA_W, 32: bus data width; 32 or 64 only.
- ADDR_W, 32: byte address width.
- NB (derived), DATA_W/8: number of byte lanes.
- OFS_W (derived), log2(NB): address bits used to select a lane.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core request present.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword (dword valid only when DATA_W=64).
- req_signed  in  1  sign-extend load result.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- resp_valid  out  1  one-cycle completion strobe.
- resp_rdata  out  DATA_W  extended load data; 0 for stores.
- resp_fault  out  1  access rejected; qualified by resp_valid.
- address  out  ADDR_W  Avalon address, aligned to NB.
- read, write  out  1  Avalon strobes.
- waitrequest  in  1  Avalon stall.
- writedata  out  DATA_W  lane-steered store data.
- byteenable  out  NB  active byte lanes.
- readdata  in  DATA_W  Avalon read data, valid when read=1 and waitrequest=0.

## Operation
- States: IDLE, BUS, RESP.
- IDLE: req_ready=1. When req_valid=1, register addr/size/signed/write/wdata. Next state is BUS, or RESP with fault if the request is illegal.
- Illegal requests are: size=3 when DATA_W=32, and a misaligned access (see Configuration).
- BUS: read=~write_q and write=write_q. address={addr_q[ADDR_W-1:OFS_W], OFS_W'b0}.
- Let ofs = addr_q[OFS_W-1:0] and mask = (1<<(1<<size_q))-1.
- byteenable = mask<<ofs, truncated to NB bits.
- writedata = wdata_q<<(8*ofs).
- All bus outputs are held constant while waitrequest=1.
- On the first BUS cycle with waitrequest=0, capture readdata and go to RESP.
- Load result: (readdata>>(8*ofs)) masked to 8<<size_q bits. Bits above that width are filled with the MSB of the field when signed_q=1, else with 0.
- RESP: resp_valid=1 for exactly one cycle, then return to IDLE. req_ready=0 in BUS and RESP.
- Lanes are little-endian: lane i carries writedata[8i+7:8i].
- Only one transaction is outstanding at a time. There is no queue.

## Timing
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, read=0, write=0, address=0, writedata=0, byteenable=0.
- Request accepted at edge N. read/write are asserted in cycle N+1. With waitrequest=0, resp_valid is high in cycle N+2.
- Each waitrequest=1 cycle adds one cycle of latency.
- A faulting request skips BUS: resp_valid=1 and resp_fault=1 in cycle N+1. No bus strobe is issued.
- Back-to-back throughput is one access per 3 cycles; the next accept happens in the cycle after RESP.
- Reset asserted in any state: at the next edge all outputs return to reset values. A pending bus strobe is dropped and no response is issued.
- req_valid while not ready is ignored. The core must hold the request until it sees req_ready.

## Configuration
- MIPS_BUS_LSU_ALIGN_CHECK_EN defined: an access is misaligned when addr[size-1:0]≠0, i.e. any half/word/dword not aligned to its own size. A misaligned access faults without a bus transaction.
- Not defined: no fault for misalignment. The low size bits of the address are forced to zero before lane computation, so the access is silently aligned down.
- The size=3 fault on a 32-bit bus is present in both builds.

## Test plan
- DATA_W=32, load byte, addr 0x1003, signed, readdata 0x80FF_1234: address=0x1000, byteenable=4'b1000, resp_rdata=0xFFFF_FF80.
- DATA_W=32, store half, addr 0x2002, wdata 0x0000_BEEF, waitrequest high 3 cycles: write is held with constant address 0x2000, byteenable=4'b1100, writedata=0xBEEF_0000. resp_valid occurs 5 cycles after accept.
- DATA_W=64, unsigned word load, addr 0x14, readdata 0x8765_4321_0000_0000: address=0x10, byteenable=8'hF0, resp_rdata=0x0000_0000_8765_4321.
- Word load at addr 0x1002:
  - With ALIGN_CHECK_EN: resp_fault=1 one cycle after accept, and read never rises.
  - Without it: address=0x1000, byteenable=4'hF.
- Reset asserted while in BUS with waitrequest=1: read=0 the next cycle, resp_valid stays 0, req_ready=1.
- DATA_W=32, size=3: fault response and no bus strobe, in both builds.
